// File: rtl/inst_fetch_pkg.sv
// Shared widths, jump/stall encodings and fetch FSM states for the instruction-fetch stage.
package inst_fetch_pkg;

  localparam int RAMAddrLen    = 17;
  localparam int InstLen       = 32;
  localparam int JumpInfoLen   = 2;
  localparam int Jump_ID       = 0;
  localparam int Jump_EX       = 1;
  localparam int StallLevelLen = 3;

  localparam logic [InstLen-1:0] ZeroWord = '0;

  localparam logic [StallLevelLen-1:0] Stall_Null = 3'd0;
  localparam logic [StallLevelLen-1:0] Stall_IF   = 3'd1;
  localparam logic [StallLevelLen-1:0] Stall_ID   = 3'd2;
  localparam logic [StallLevelLen-1:0] Stall_EX   = 3'd3;
  localparam logic [StallLevelLen-1:0] Stall_All  = 3'd4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } if_state_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-side memory bus: level request/address out, one-cycle done pulse with the word back.
interface inst_fetch_if #(
  parameter int ADDR_W = 17
);
  import inst_fetch_pkg::*;

  logic                mem_req;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_done;
  logic [InstLen-1:0]  mem_inst;

  modport master (output mem_req, output mem_addr, input  mem_done, input  mem_inst);
  modport slave  (input  mem_req, input  mem_addr, output mem_done, output mem_inst);
endinterface

// File: rtl/inst_fetch.sv
// PC + fetch FSM; word presented the cycle after mem_done, held until released by Stall_Null.
// Jumps redirect from any state; an in-flight word is drained and never presented.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int                ADDR_W   = RAMAddrLen,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [JumpInfoLen-1:0]   jp,
  input  logic [ADDR_W-1:0]        jp_target_id,
  input  logic [ADDR_W-1:0]        jp_target_ex,
  input  logic [StallLevelLen-1:0] stall_command,
  inst_fetch_if.master             mem,
  output logic [ADDR_W-1:0]        if_pc,
  output logic [InstLen-1:0]       if_inst,
  output logic                     if_stall_req
);

  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  buf_pc;
  logic [InstLen-1:0] buf_inst;
  if_state_t          state;

  logic               jump;
  logic [ADDR_W-1:0]  target;
  logic               hold;

  assign jump   = jp[Jump_EX] | jp[Jump_ID];
  assign target = jp[Jump_EX] ? jp_target_ex : jp_target_id;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc       <= RESET_PC;
      state    <= FETCH;
      buf_pc   <= '0;
      buf_inst <= ZeroWord;
    end else begin
      unique case (state)
        FETCH: begin
          if (jump) begin
            pc <= target;
            // A word landing together with the jump is simply dropped.
            if (!mem.mem_done) state <= DRAIN;
          end else if (mem.mem_done) begin
            buf_inst <= mem.mem_inst;
            buf_pc   <= pc;
            state    <= HOLD;
          end
        end
        DRAIN: begin
          if (jump) pc <= target;
          if (mem.mem_done) state <= FETCH;
        end
        HOLD: begin
          if (jump) begin
            pc       <= target;
            buf_pc   <= '0;
            buf_inst <= ZeroWord;
            state    <= FETCH;
          end else if (stall_command == Stall_Null) begin
            pc    <= pc + ADDR_W'(4);
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  // Outputs are gated by rst so nothing leaks out while reset is held low.
  assign hold         = rst && (state == HOLD);
  assign mem.mem_req  = rst && (state == FETCH);
  assign mem.mem_addr = pc;
  assign if_pc        = hold ? buf_pc : '0;
  assign if_inst      = hold ? buf_inst : ZeroWord;
  assign if_stall_req = !hold;

endmodule
